// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the target and the master core.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic [I2C_BYTE_W-1:0] I2C_IDLE_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the SCL/SDA pads and derives SCL edges plus START/STOP conditions.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_meta_q, scl_sync_q, scl_dly_q;
  logic sda_meta_q, sda_sync_q, sda_dly_q;

  // Reset to the idle-high bus level so release from reset creates no false edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_dly_q  <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_dly_q  <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_dly_q  <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_dly_q;
  assign scl_fall  = ~scl_sync_q & scl_dly_q;
  assign start_det = scl_sync_q & scl_dly_q & sda_dly_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_dly_q & ~sda_dly_q & sda_sync_q;
  assign sda_s     = sda_sync_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: fixed 7-bit address, RX byte delivery, TX holding register.
// Optional SCL stretching on an empty TX holding register: I2C_TARGET_CLK_STRETCH_EN.
//
// state        | meaning
// ST_IDLE      | bus free or not yet addressed, waiting for START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving ACK for the address byte
// ST_RX        | shifting in a write byte
// ST_RX_ACK    | driving ACK for a write byte
// ST_TX        | shifting out a read byte
// ST_TX_ACK    | SDA released, sampling master ACK/NACK
// ST_WAIT_STOP | not addressed or NACKed, ignoring traffic until START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire                   scl,
  inout  wire                   sda,
  output logic [I2C_BYTE_W-1:0] data_out,
  output logic                  data_valid,
  input  logic [I2C_BYTE_W-1:0] data_in,
  input  logic                  wr_data,
  output logic                  tx_req,
  output logic                  busy,
  output logic                  underrun
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_tgt_state_t state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [I2C_BYTE_W-1:0] hold_q, hold_d;
  logic [I2C_BYTE_W-1:0] data_out_q, data_out_d;
  logic hold_full_q, hold_full_d;
  logic sda_low_q, sda_low_d;
  logic data_valid_q, data_valid_d;
  logic tx_req_q, tx_req_d;
  logic busy_q, busy_d;
  logic underrun_q, underrun_d;
  logic load, wr_taken;

`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic stretch_q, stretch_d, scl_low_q;
`endif

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl),
    .sda_i     (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    data_out_d   = data_out_q;
    sda_low_d    = sda_low_q;
    data_valid_d = 1'b0;
    tx_req_d     = 1'b0;
    busy_d       = busy_q;
    underrun_d   = underrun_q;
    load         = 1'b0;
    wr_taken     = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    stretch_d    = stretch_q;
`endif

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      cnt_d     = 4'd0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_d   = ST_ADDR_ACK;
              sda_low_d = 1'b1;
              busy_d    = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d = ST_TX;
              load    = 1'b1;
            end else begin
              state_d   = ST_RX;
              sda_low_d = 1'b0;
            end
          end
        end
        ST_RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            sda_low_d    = 1'b1;
            state_d      = ST_RX_ACK;
            cnt_d        = 4'd0;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            state_d   = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              state_d   = ST_TX_ACK;
              cnt_d     = 4'd0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b1};
              sda_low_d = ~shift_q[6];
            end
          end
        end
        ST_TX_ACK: begin
          // Only an ACK survives to the falling edge; NACK leaves on the rise.
          if (scl_rise && sda_s) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall) begin
            state_d = ST_TX;
            cnt_d   = 4'd0;
            load    = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load) begin
      tx_req_d = 1'b1;
      if (hold_full_q) begin
        shift_d     = hold_q;
        sda_low_d   = ~hold_q[7];
        hold_full_d = 1'b0;
      end else begin
        shift_d   = I2C_IDLE_BYTE;
        sda_low_d = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        stretch_d = 1'b1;
`else
        underrun_d = 1'b1;
`endif
      end
    end

`ifdef I2C_TARGET_CLK_STRETCH_EN
    if (stop_det || start_det) begin
      stretch_d = 1'b0;
    end else if (stretch_q) begin
      if (hold_full_q) begin
        shift_d     = hold_q;
        sda_low_d   = ~hold_q[7];
        hold_full_d = 1'b0;
        stretch_d   = 1'b0;
      end else if (wr_data) begin
        shift_d   = data_in;
        sda_low_d = ~data_in[7];
        stretch_d = 1'b0;
        wr_taken  = 1'b1;
      end
    end
`endif

    // A same-clk write lands after any consume, so it refills the emptied register.
    if (wr_data && !wr_taken) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
    if (wr_data) underrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      data_out_q   <= '0;
      sda_low_q    <= 1'b0;
      data_valid_q <= 1'b0;
      tx_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      data_out_q   <= data_out_d;
      sda_low_q    <= sda_low_d;
      data_valid_q <= data_valid_d;
      tx_req_q     <= tx_req_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

`ifdef I2C_TARGET_CLK_STRETCH_EN
  // SCL follows the stretch flag one clk late, so SDA is settled before release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stretch_q <= 1'b0;
      scl_low_q <= 1'b0;
    end else begin
      stretch_q <= stretch_d;
      scl_low_q <= stretch_q;
    end
  end
  assign scl = scl_low_q ? 1'b0 : 1'bz;
`else
  assign scl = 1'bz;
`endif

  assign sda        = sda_low_q ? 1'b0 : 1'bz;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign tx_req     = tx_req_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) for the 50 MHz system clock domain: the far end of the I2C master core on the same bus. Oversamples SCL/SDA, detects START/STOP, matches a fixed 7-bit address, ACKs and delivers written bytes to the user side, and serialises user-supplied bytes on reads. SDA is open-drain. Standard and fast mode.

## Interface
- `TARGET_ADDR`, default 7'h50: 7-bit bus address this target answers to.
- `clk` input, 1 bit: system clock, 50 MHz.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `scl` inout, 1 bit: serial clock. Input-only (never driven) unless `I2C_TARGET_CLK_STRETCH_EN` is defined.
- `sda` inout, 1 bit: serial data. Driven only as 1'b0; otherwise 1'bz.
- `data_out` output, 8 bits: last byte written by the master.
- `data_valid` output, 1 bit: one-clk strobe; `data_out` is new.
- `data_in` input, 8 bits: next byte to return on a master read.
- `wr_data` input, 1 bit: one-clk load strobe for `data_in` into the TX holding register.
- `tx_req` output, 1 bit: one-clk strobe; the TX holding register was consumed, load the next byte.
- `busy` output, 1 bit: high from an addressed START until STOP.
- `underrun` output, 1 bit: sticky; a read byte was needed while the TX holding register was empty. Cleared by `wr_data`.

## Operation
- **Input conditioning:** 2-FF synchroniser on `scl` and `sda`, then a 1-FF delay used for edge detection.
- **START:** synced SDA falls while synced SCL is high. START is accepted in any state, which covers repeated START; it clears the bit counter and enters ADDR.
- **STOP:** synced SDA rises while synced SCL is high. STOP from any state enters IDLE, releases SDA and drops `busy`.
- **Bit sampling and driving:** SDA is sampled on the synced SCL rising edge. SDA is driven/changed only on the synced SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- **ADDR:** shift 8 bits, MSB first. If bits[7:1] equal `TARGET_ADDR`, go to ADDR_ACK and assert `busy`; otherwise go to WAIT_STOP with SDA released (NACK).
- **ADDR_ACK:** drive SDA low for the 9th clock. Then R/W=0 goes to RX; R/W=1 loads the shift register from the holding register and goes to TX.
- **RX:** after the 8th bit, update `data_out` and pulse `data_valid` on the same falling edge that starts the ACK. RX_ACK always ACKs, then returns to RX.
- **TX:** shift MSB first; a 1 bit releases SDA, a 0 bit drives low. The shift register load empties the holding register and pulses `tx_req`. If the holding register is empty at load time, send 8'hFF and set `underrun`.
- **TX_ACK:** release SDA and sample the master's bit at the 9th SCL rise. 0 (ACK) loads the next byte and continues in TX; 1 (NACK) goes to WAIT_STOP.
- **WAIT_STOP:** ignore traffic until START or STOP.
- **`wr_data` in the same clk as a consume:** the new byte fills the now-empty holding register and `underrun` is not set.

## Timing
- Pad-to-detection latency is 3 clks (60 ns) for both edges and START/STOP. SDA output changes 3–4 clks after the pad SCL falls, which is within I2C hold limits.
- Minimum supported SCL high/low time is 8 clks; no glitch filter.
- `data_valid` and `tx_req` are single-clk pulses.
- **Reset values:** `data_out`=8'h00, `data_valid`=0, `tx_req`=0, `busy`=0, `underrun`=0, SDA/SCL released, state IDLE, holding register empty.
- Reset asserted mid-transfer releases the lines immediately (asynchronous). After release, the target waits in IDLE for the next START.

## Configuration
- **`I2C_TARGET_CLK_STRETCH_EN` defined:** on a TX load with an empty holding register, the target holds SCL low (stretching) from that falling edge until `wr_data`. It then loads the byte and releases SCL 1 clk later; `underrun` is never set. A STOP or START seen while stretching aborts the stretch.
- **Undefined:** `scl` is never driven; the 8'hFF/`underrun` behaviour applies.

## Structure
- **Shared package `i2c_pkg`:** state enum `i2c_tgt_state_t`, `I2C_ADDR_W`=7, `I2C_BYTE_W`=8, `I2C_IDLE_BYTE`=8'hFF. The master core side imports the same package.
- **Sub-module `i2c_line_sync`:** synchronisers, delay FFs, and outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`. The top holds the FSM, shift register, bit counter and TX holding register.

## Test plan
- **Write, matching address:** START, 0xA0 (0x50 + W), 0xA5, STOP → ACK on both bytes; `data_out`=0xA5 with one `data_valid` pulse; `busy` 1→0 at STOP.
- **Address mismatch:** START, 0xA2, 0x11, STOP → SDA released on both 9th clocks; no `data_valid`; `busy` stays 0.
- **Read:** preload 0x3C via `wr_data`; START, 0xA1, master NACK → bus carries 0x3C; `tx_req` pulses at load; SDA released; WAIT_STOP until STOP.
- **Repeated START:** write 0x01, Sr, read with preload 0x7E and master ACK then NACK, no preload for 2nd byte → bytes 0x7E then 0xFF; `underrun`=1 (macro off). Macro on: SCL held low until `wr_data`(0x42), then byte 0x42 and `underrun`=0.
- **Reset mid-byte:** assert `reset` after 4 data bits of a write → SDA/SCL released within the same clk; all outputs at reset values; next full write transaction is ACKed normally.
- **Simultaneous consume and `wr_data`:** `wr_data` pulsed in the same clk as `tx_req` → next byte is the new `data_in`; `underrun` stays 0.
